// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer FSM states
//   fetch_entry_t : one fetched word {pc, inst} as held in the fetch queue
//   IMEM_DEPTH    : instruction memory size in words
//   FETCH_Q_DEPTH : number of entries in the fetch queue
package fetch_pkg;

  localparam int IMEM_DEPTH    = 128;
  localparam int FETCH_Q_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: valid/ready handshake from the fetch sequencer to decode.
//   out_valid : queue head valid          (master -> slave)
//   out_ready : decode accepts the head    (slave -> master)
//   out_inst  : head instruction word      (master -> slave)
//   out_pc    : PC of the head instruction (master -> slave)
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;

  modport master (output out_valid, out_inst, out_pc, input out_ready);
  modport slave  (input out_valid, out_inst, out_pc, output out_ready);
endinterface

// File: rtl/fetch_sequencer_queue.sv
// fetch_queue: 2-entry FIFO of fetch_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue; wins over a simultaneous push
//   head       : current head entry (meaningful when count != 0)
//   count      : number of valid entries, 0..2
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot [FETCH_Q_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'(FETCH_Q_DEPTH));
  assign do_pop  = pop && (count != 2'd0);
  assign head    = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_Q_DEPTH; i++) slot[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller in front of a synchronous,
// word-addressed instruction memory (data valid one cycle after the address).
// Keeps at most one read in flight, buffers returned words in a 2-entry queue
// and hands {pc, inst} to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : pulse, leave IDLE/HALT and begin fetching
//   halt_req       : stop issuing new fetches (enter HALT)
//   redirect_valid : branch/jump taken; flush queue, squash in-flight read
//   redirect_pc    : new fetch address
//   imem_addr      : word address to instruction memory
//   imem_inst      : memory data for the address issued the previous cycle
//   dec            : decode handshake (fetch_sequencer_if.master)
//   busy           : FETCH state, read in flight, or queue non-empty
//   fault          : sticky out-of-range flag
//
// Build option: FETCH_BOUNDS_CHECK_EN -- when defined, an out-of-range fetch
// or redirect PC parks the sequencer in FAULT; otherwise PCs wrap modulo DEPTH
// and fault is tied 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, nothing issued; waits for start
// ST_FETCH | issuing reads whenever queue + in-flight have room
// ST_HALT  | no new issues; outstanding work drains; start resumes
// ST_FAULT | out-of-range PC seen; drains, exits on in-range redirect only
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = IMEM_DEPTH,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      halt_req,
  input  logic                      redirect_valid,
  input  logic [PC_W-1:0]           redirect_pc,
  output logic [PC_W-1:0]           imem_addr,
  input  logic [31:0]               imem_inst,
  fetch_sequencer_if.master         dec,
  output logic                      busy,
  output logic                      fault
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redir_pc_eff;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            flush;
  logic            issue_try;
  logic            issue;
  logic            pc_oor;
  logic            redir_oor;
  int              credit;
  logic [1:0]      q_count;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign pc_oor       = fetch_pc >= PC_W'(DEPTH);
  assign redir_oor    = redirect_pc >= PC_W'(DEPTH);
  assign pc_inc       = fetch_pc + PC_W'(1);
  assign redir_pc_eff = redirect_pc;
`else
  assign pc_oor       = 1'b0;
  assign redir_oor    = 1'b0;
  assign pc_inc       = (fetch_pc == PC_W'(DEPTH - 1)) ? '0 : fetch_pc + PC_W'(1);
  assign redir_pc_eff = redirect_pc % PC_W'(DEPTH);
`endif

  assign pop    = dec.out_valid && dec.out_ready;
  // Room left once this cycle's pop retires; the in-flight word already owns a slot.
  assign credit = FETCH_Q_DEPTH - int'(q_count) - int'(inflight) + int'(pop);
  assign issue_try = (state == ST_FETCH) && !redirect_valid && !halt_req && (credit > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = redir_oor ? ST_FAULT : ST_FETCH;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: if (!halt_req && start) state_nxt = ST_FETCH;
        ST_FETCH: begin
          if (halt_req)                  state_nxt = ST_HALT;
          else if (issue_try && pc_oor)  state_nxt = ST_FAULT;
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    issue = issue_try && !pc_oor;
    push  = inflight && !redirect_valid;
    flush = redirect_valid;
    busy  = (state == ST_FETCH) || inflight || (q_count != 2'd0);
    fault = (state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      inflight <= 1'b0;
      if (!redir_oor) fetch_pc <= redir_pc_eff;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= pc_inc;
      end
    end
  end

  assign q_push_data.pc   = 32'(inflight_pc);
  assign q_push_data.inst = imem_inst;

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (q_push_data),
    .head      (q_head),
    .count     (q_count)
  );

  assign imem_addr     = fetch_pc;
  assign dec.out_valid = (q_count != 2'd0);
  assign dec.out_inst  = dec.out_valid ? q_head.inst : '0;
  assign dec.out_pc    = dec.out_valid ? PC_W'(q_head.pc) : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer.
// A stream model tracks which PC decode must see next (sequential from the
// last start/redirect, wrapping or faulting at DEPTH) and a per-cycle compare
// process checks every handshake, hold stability and post-redirect flush.
// Directed steps pin latency, stall, redirect, halt and the DEPTH boundary;
// a random phase then mixes ready/redirect/halt/start.
// Build option FETCH_BOUNDS_CHECK_EN selects the fault-checking expectations.
module tb_fetch_sequencer;

  localparam int DEPTH = 128;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst = '0;
  logic        busy;
  logic        fault;
  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  fetch_sequencer_if #(.PC_W(32)) dec ();

  fetch_sequencer #(.DEPTH(DEPTH), .PC_W(32), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .dec            (dec.master),
    .busy           (busy),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_inst <= mem[imem_addr[6:0]];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] seq_next(input logic [31:0] p);
    return BOUNDS ? p + 32'd1 : (p + 32'd1) % DEPTH;
  endfunction

  function automatic bit redir_ok(input logic [31:0] p);
    return !BOUNDS || (p < DEPTH);
  endfunction

  function automatic logic [31:0] redir_eff(input logic [31:0] p);
    return BOUNDS ? p : p % DEPTH;
  endfunction

  // ---------------- stream model + per-cycle compare ----------------
  logic [31:0] exp_pc = '0;
  bit          prev_hold = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] hold_pc, hold_inst;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc     = 32'd0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) begin
        check("flush_after_redirect", dec.out_valid, 1'b0);
      end else if (prev_hold) begin
        check("hold_valid", dec.out_valid, 1'b1);
        check("hold_pc", dec.out_pc, hold_pc);
        check("hold_inst", dec.out_inst, hold_inst);
      end
      if (dec.out_valid && dec.out_ready) begin
        check("stream_pc", dec.out_pc, exp_pc);
        check("stream_inst", dec.out_inst, mem[exp_pc[6:0]]);
        exp_pc = seq_next(exp_pc);
      end
      prev_hold  = dec.out_valid && !dec.out_ready && !redirect_valid;
      hold_pc    = dec.out_pc;
      hold_inst  = dec.out_inst;
      prev_redir = redirect_valid;
      if (redirect_valid && redir_ok(redirect_pc)) exp_pc = redir_eff(redirect_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] resume;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) + 32'h100;
    dec.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_out_valid", dec.out_valid, 1'b0);
    check("rst_out_inst", dec.out_inst, 32'd0);
    check("rst_out_pc", dec.out_pc, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst_n = 1'b1;
    step(); step();
    check("idle_valid", dec.out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);

    // start: out_valid from E2
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_e0_valid", dec.out_valid, 1'b0);
    check("start_e0_busy", busy, 1'b1);
    step();
    check("start_e1_valid", dec.out_valid, 1'b0);
    step();
    check("start_e2_valid", dec.out_valid, 1'b1);
    check("start_e2_pc", dec.out_pc, 32'd0);
    check("start_e2_inst", dec.out_inst, 32'h100);
    step();
    check("start_e3_pc", dec.out_pc, 32'd1);
    check("start_e3_inst", dec.out_inst, 32'h101);
    for (int k = 0; k < 10; k++) begin
      step();
      check("throughput_valid", dec.out_valid, 1'b1);
    end

    // stall 5 cycles: queue full, address held two past the head
    dec.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", dec.out_valid, 1'b1);
      check("stall_addr", imem_addr, exp_pc + 32'd2);
    end
    dec.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("release_valid", dec.out_valid, 1'b1);
    end

    // redirect to 0x40
    pulse_redirect(32'h40);
    check("redir_r0_valid", dec.out_valid, 1'b0);
    step();
    check("redir_r1_valid", dec.out_valid, 1'b0);
    step();
    check("redir_r2_valid", dec.out_valid, 1'b1);
    check("redir_r2_pc", dec.out_pc, 32'h40);
    check("redir_r2_inst", dec.out_inst, 32'h140);
    step();
    check("redir_r3_pc", dec.out_pc, 32'h41);
    check("redir_r3_inst", dec.out_inst, 32'h141);
    repeat (3) step();

    // halt pulse, drain, resume 6 cycles later
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    repeat (4) step();
    check("halt_busy", busy, 1'b0);
    check("halt_valid", dec.out_valid, 1'b0);
    step();
    resume = exp_pc;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("resume_valid", dec.out_valid, 1'b1);
    check("resume_pc", dec.out_pc, resume);
    check("resume_inst", dec.out_inst, mem[resume[6:0]]);
    repeat (3) step();

    // run across the top of memory
    pulse_redirect(32'd126);
    step(); step();
    check("edge_pc126", dec.out_pc, 32'd126);
    check("edge_inst126", dec.out_inst, 32'h17E);
    step();
    check("edge_pc127", dec.out_pc, 32'd127);
    check("edge_inst127", dec.out_inst, 32'h17F);
    check("edge_fault127", fault, BOUNDS);
    step();
    if (BOUNDS) begin
      check("fault_valid", dec.out_valid, 1'b0);
      check("fault_flag", fault, 1'b1);
      check("fault_busy", busy, 1'b0);
      repeat (3) step();
      check("fault_still_idle", dec.out_valid, 1'b0);
      check("fault_sticky", fault, 1'b1);
    end else begin
      check("wrap_valid", dec.out_valid, 1'b1);
      check("wrap_pc", dec.out_pc, 32'd0);
      check("wrap_inst", dec.out_inst, 32'h100);
      check("wrap_fault", fault, 1'b0);
    end
    pulse_redirect(32'd5);
    check("redir5_fault", fault, 1'b0);
    step(); step();
    check("redir5_pc", dec.out_pc, 32'd5);
    check("redir5_inst", dec.out_inst, 32'h105);

    // out-of-range redirect: modulo or fault
    pulse_redirect(32'd200);
    check("oor_fault", fault, BOUNDS);
    step(); step();
    if (BOUNDS) begin
      check("oor_valid", dec.out_valid, 1'b0);
    end else begin
      check("oor_pc", dec.out_pc, 32'd72);
      check("oor_inst", dec.out_inst, 32'h148);
    end
    pulse_redirect(32'd5);
    check("oor_clear", fault, 1'b0);
    repeat (2) step();

    // random mix
    for (int k = 0; k < 400; k++) begin
      dec.out_ready  = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = BOUNDS ? $urandom_range(0, 127) : $urandom_range(0, 255);
      halt_req       = ($urandom_range(0, 99) < 3);
      start          = ($urandom_range(0, 99) < 10);
      step();
    end
    halt_req = 1'b0;
    start = 1'b0;
    dec.out_ready = 1'b1;
    pulse_redirect(32'd10);
    step(); step();
    check("post_rand_pc", dec.out_pc, 32'd10);
    check("post_rand_fault", fault, 1'b0);
    repeat (3) step();

    // asynchronous reset mid-stream
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", dec.out_valid, 1'b0);
    check("async_rst_addr", imem_addr, 32'd0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_pc", dec.out_pc, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
